m_control: RTL
==============

Name: m_control

Overview:
- Sequencing FSM for the RV32M multiply/divide unit.
- Sits directly upstream of the datapath register block (m_registers) and drives its mux selects every cycle.
- Decodes funct3, runs one multiply (via the DSP) or one 32-iteration restoring divide, then signals completion.
- Also tells the output stage which register holds the result and whether to negate it.

Parameters:
- MUL_LATENCY, 1: DSP multiplier pipeline depth in cycles (>=1); number of MUL_WAIT cycles.
- DIV_STEPS, 32: restoring-division iterations; fixed for RV32.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  operation request; sampled only in IDLE.
- funct3  in  3  M-extension opcode: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
- rs1_msb  in  1  rs1[31], valid with start.
- rs2_msb  in  1  rs2[31], valid with start.
- rs2_zero  in  1  rs2==0, valid with start.
- sub_neg  in  1  combinational subtractor borrow (R minus D[62:31]) from the datapath.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result valid in the datapath registers.
- mux_A  out  MUX_A_LENGTH  datapath A select.
- mux_B  out  MUX_B_LENGTH  datapath B select.
- mux_R  out  MUX_R_LENGTH  remainder/low-product register select.
- mux_D  out  MUX_D_LENGTH  divisor register select.
- mux_Z  out  MUX_Z_LENGTH  quotient/high-product register select.
- result_signed  out  1  high-product sign handling for MULH/MULHSU.
- result_sel  out  1  0 = result in R, 1 = result in Z; held from start until the next start.
- negate_result  out  1  output stage two's-complements the selected result; held like result_sel.

Behaviour:
- Reset (synchronous, active-high) values: state=IDLE, busy=0, done=0, result_sel=0, negate_result=0, result_signed=0, counter=0; mux_R/D/Z=KEEP, mux_A/B=KEEP.
- Default outputs in every state unless listed: mux_R/D/Z=KEEP, mux_A/B=KEEP, result_signed=0.
- IDLE with start=1 (Mealy load cycle):
  - Multiply: mux_R=A, mux_D=B.
  - Divide, signed and msb set: mux_R=A_NEG / mux_D=B_NEG; otherwise A / B.
  - Always mux_Z=ZERO.
  - Register op, result_sel, negate flags and div-by-zero flag.
  - Next state: MUL_OPS (funct3[2]=0) or DIV_ITER (funct3[2]=1); busy=1 from the next cycle.
- result_sel: 0 for MUL, REM, REMU; 1 for MULH, MULHSU, MULHU, DIV, DIVU.
- MUL_OPS (1 cycle): set mux_A/mux_B per op, then go to MUL_WAIT.
  - MUL: A unsigned, B unsigned.
  - MULH: A signed, B signed.
  - MULHSU: A signed, B unsigned.
  - MULHU: A unsigned, B unsigned.
- MUL_WAIT: MUL_LATENCY cycles; mux_A/B=KEEP; down-counter, then go to MUL_CAPTURE.
- MUL_CAPTURE (1 cycle): mux_R=MULT_LOWER, mux_Z=MULT_UPPER; result_signed=1 for MULH/MULHSU; then go to DONE.
- Multiply latency: done asserted MUL_LATENCY+3 cycles after the start cycle.
- DIV_ITER: DIV_STEPS cycles.
  - mux_R=SUB_KEEP, mux_Z=SHL_ADD, mux_D=SHR, mux_A/B=ZERO.
  - 5-bit counter loaded with 31; go to DONE when the counter is 0 at a clock edge.
- Divide latency: done asserted DIV_STEPS+1 cycles after the start cycle.
- Sign fix (negate_result):
  - DIV: rs1_msb XOR rs2_msb, forced 0 when rs2_zero.
  - REM: rs1_msb.
  - Unsigned ops and all multiplies: 0.
- Boundary results:
  - x/0 gives Z=0xFFFFFFFF and R=|x|; with the rules above, DIV=-1 and REM=x.
  - 0x80000000 / -1 needs no special case: Z=0x80000000, R=0.
- DONE (1 cycle): done=1, busy=0; next state IDLE.
  - start in DONE is ignored; back-to-back issue requires start in the following IDLE cycle.
- start while busy: ignored, no effect.
- funct3 and msb inputs: only meaningful with start in IDLE.
- Reset mid-operation: next cycle is IDLE with reset values; no done pulse for the aborted operation.

Decomposition:
- Package m_pkg:
  - state typedef enum: IDLE, MUL_OPS, MUL_WAIT, MUL_CAPTURE, DIV_ITER, DONE.
  - funct3 constants.
  - mux encodings stay in m_definitions.svh (MUX_*_LENGTH and values), included by both blocks.
- One natural combinational sub-module m_op_decode: funct3, rs1_msb, rs2_msb, rs2_zero in; is_div, a_signed, b_signed, load_neg_a, load_neg_b, result_sel, negate_result, result_signed out.

Test Plan (bench instantiates m_control with m_registers, a reference subtractor/DSP model and a result mux):
1. MUL, rs1=7, rs2=0xFFFFFFFD, MUL_LATENCY=1 -> done at cycle 4 after start; result_sel=0; result 0xFFFFFFEB; busy high cycles 1-3 only.
2. MULH, rs1=rs2=0x80000000 -> result_signed=1 in capture cycle; Z=0x40000000; MULHU same operands -> Z=0x40000000, result_signed=0.
3. DIV, rs1=0xFFFFFFF9 (-7), rs2=2 -> done at cycle 33; negate_result=1; result 0xFFFFFFFD. REM with same operands -> 0xFFFFFFFF.
4. DIV 5/0 -> 0xFFFFFFFF, negate_result=0. REM 0xFFFFFFFB/0 -> 0xFFFFFFFB. DIVU 5/0 -> 0xFFFFFFFF.
5. DIV 0x80000000 / 0xFFFFFFFF -> Z=0x80000000, negate_result=0; REM same operands -> 0.
6. start re-asserted with different funct3 at iteration 10 -> ignored, original result correct. Then reset at iteration 10 of a new DIV -> next cycle IDLE, busy=0, all mux selects KEEP, no done. A subsequent MUL completes correctly.

Source files
------------

// File: rtl/m_pkg.sv
// rtl/m_pkg.sv - shared state type, funct3 codes and mux encodings for the RV32M control block
//
// Purpose: types and constants used by m_control, m_op_decode and the datapath.
// The mux encodings are the contract with the datapath register block.
package m_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL_OPS,
    MUL_WAIT,
    MUL_CAPTURE,
    DIV_ITER,
    DONE
  } m_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Shared down-counter for multiply wait cycles and divide iterations.
  localparam int CNT_W = 5;

  localparam int MUX_A_LENGTH = 2;
  localparam int MUX_B_LENGTH = 2;
  localparam int MUX_R_LENGTH = 3;
  localparam int MUX_D_LENGTH = 2;
  localparam int MUX_Z_LENGTH = 2;

  localparam logic [MUX_A_LENGTH-1:0] MUX_A_KEEP     = 2'd0;
  localparam logic [MUX_A_LENGTH-1:0] MUX_A_ZERO     = 2'd1;
  localparam logic [MUX_A_LENGTH-1:0] MUX_A_UNSIGNED = 2'd2;
  localparam logic [MUX_A_LENGTH-1:0] MUX_A_SIGNED   = 2'd3;

  localparam logic [MUX_B_LENGTH-1:0] MUX_B_KEEP     = 2'd0;
  localparam logic [MUX_B_LENGTH-1:0] MUX_B_ZERO     = 2'd1;
  localparam logic [MUX_B_LENGTH-1:0] MUX_B_UNSIGNED = 2'd2;
  localparam logic [MUX_B_LENGTH-1:0] MUX_B_SIGNED   = 2'd3;

  localparam logic [MUX_R_LENGTH-1:0] MUX_R_KEEP       = 3'd0;
  localparam logic [MUX_R_LENGTH-1:0] MUX_R_A          = 3'd1;
  localparam logic [MUX_R_LENGTH-1:0] MUX_R_A_NEG      = 3'd2;
  localparam logic [MUX_R_LENGTH-1:0] MUX_R_SUB_KEEP   = 3'd3;
  localparam logic [MUX_R_LENGTH-1:0] MUX_R_MULT_LOWER = 3'd4;

  localparam logic [MUX_D_LENGTH-1:0] MUX_D_KEEP  = 2'd0;
  localparam logic [MUX_D_LENGTH-1:0] MUX_D_B     = 2'd1;
  localparam logic [MUX_D_LENGTH-1:0] MUX_D_B_NEG = 2'd2;
  localparam logic [MUX_D_LENGTH-1:0] MUX_D_SHR   = 2'd3;

  localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_KEEP       = 2'd0;
  localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_ZERO       = 2'd1;
  localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_SHL_ADD    = 2'd2;
  localparam logic [MUX_Z_LENGTH-1:0] MUX_Z_MULT_UPPER = 2'd3;

endpackage

// File: rtl/m_control_op_decode.sv
// rtl/m_control_op_decode.sv - combinational funct3/operand-sign decode for the RV32M control block
//
// Purpose: turns funct3 and the operand sign/zero flags into the per-operation
// control bits that m_control registers on the load cycle.
// Ports:
//   funct3         in   M-extension opcode
//   rs1_msb        in   rs1[31]
//   rs2_msb        in   rs2[31]
//   rs2_zero       in   rs2 == 0
//   is_div         out  divide/remainder family
//   a_signed       out  multiplier A operand is signed
//   b_signed       out  multiplier B operand is signed
//   load_neg_a     out  load |rs1| (signed divide with negative dividend)
//   load_neg_b     out  load |rs2| (signed divide with negative divisor)
//   result_sel     out  0 = result in R, 1 = result in Z
//   negate_result  out  output stage negates the result
//   result_signed  out  high product needs signed handling
module m_op_decode
  import m_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       rs1_msb,
  input  logic       rs2_msb,
  input  logic       rs2_zero,
  output logic       is_div,
  output logic       a_signed,
  output logic       b_signed,
  output logic       load_neg_a,
  output logic       load_neg_b,
  output logic       result_sel,
  output logic       negate_result,
  output logic       result_signed
);

  logic div_signed;

  always_comb begin
    is_div     = funct3[2];
    // DIV and REM are the signed divides: funct3[0] clear.
    div_signed = funct3[2] & ~funct3[0];
    a_signed   = (funct3 == F3_MULH) | (funct3 == F3_MULHSU);
    b_signed   = (funct3 == F3_MULH);
    load_neg_a = div_signed & rs1_msb;
    load_neg_b = div_signed & rs2_msb;
    // Quotient and high product live in Z; remainder and low product in R.
    result_sel = funct3[2] ? ~funct3[1] : (funct3[1:0] != 2'b00);

    negate_result = 1'b0;
    if (funct3 == F3_DIV) begin
      // x/0 must return all ones, so the quotient sign fix is suppressed.
      negate_result = (rs1_msb ^ rs2_msb) & ~rs2_zero;
    end else if (funct3 == F3_REM) begin
      negate_result = rs1_msb;
    end

    result_signed = a_signed;
  end

endmodule

// File: rtl/m_control.sv
// rtl/m_control.sv - sequencing FSM for the RV32M multiply/divide unit
//
// Purpose: decodes funct3 on start, sequences one DSP multiply or one restoring
// divide by driving the datapath mux selects, then pulses done.
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   start, funct3            operation request (sampled only in IDLE) and opcode
//   rs1_msb, rs2_msb         operand sign bits, valid with start
//   rs2_zero                 divisor is zero, valid with start
//   sub_neg                  trial-subtraction borrow from the datapath
//   busy, done               operation in progress / one-cycle completion pulse
//   mux_A/B/R/D/Z            datapath select lines
//   result_signed            signed high-product handling (capture cycle only)
//   result_sel               0 = result in R, 1 = result in Z
//   negate_result            output stage two's-complements the result
module m_control
  import m_pkg::*;
#(
  parameter int MUL_LATENCY = 1,
  parameter int DIV_STEPS   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2:0]              funct3,
  input  logic                    rs1_msb,
  input  logic                    rs2_msb,
  input  logic                    rs2_zero,
  input  logic                    sub_neg,
  output logic                    busy,
  output logic                    done,
  output logic [MUX_A_LENGTH-1:0] mux_A,
  output logic [MUX_B_LENGTH-1:0] mux_B,
  output logic [MUX_R_LENGTH-1:0] mux_R,
  output logic [MUX_D_LENGTH-1:0] mux_D,
  output logic [MUX_Z_LENGTH-1:0] mux_Z,
  output logic                    result_signed,
  output logic                    result_sel,
  output logic                    negate_result
);

  m_state_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_signed_q, a_signed_d;
  logic             b_signed_q, b_signed_d;
  logic             res_signed_q, res_signed_d;
  logic             result_sel_q, result_sel_d;
  logic             negate_q, negate_d;

  logic dec_is_div, dec_a_signed, dec_b_signed;
  logic dec_load_neg_a, dec_load_neg_b;
  logic dec_result_sel, dec_negate, dec_result_signed;

  m_op_decode u_decode (
    .funct3        (funct3),
    .rs1_msb       (rs1_msb),
    .rs2_msb       (rs2_msb),
    .rs2_zero      (rs2_zero),
    .is_div        (dec_is_div),
    .a_signed      (dec_a_signed),
    .b_signed      (dec_b_signed),
    .load_neg_a    (dec_load_neg_a),
    .load_neg_b    (dec_load_neg_b),
    .result_sel    (dec_result_sel),
    .negate_result (dec_negate),
    .result_signed (dec_result_signed)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_signed_q   <= 1'b0;
      b_signed_q   <= 1'b0;
      res_signed_q <= 1'b0;
      result_sel_q <= 1'b0;
      negate_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_signed_q   <= a_signed_d;
      b_signed_q   <= b_signed_d;
      res_signed_q <= res_signed_d;
      result_sel_q <= result_sel_d;
      negate_q     <= negate_d;
    end
  end

  assign result_sel    = result_sel_q;
  assign negate_result = negate_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    a_signed_d    = a_signed_q;
    b_signed_d    = b_signed_q;
    res_signed_d  = res_signed_q;
    result_sel_d  = result_sel_q;
    negate_d      = negate_q;
    busy          = 1'b0;
    done          = 1'b0;
    mux_A         = MUX_A_KEEP;
    mux_B         = MUX_B_KEEP;
    mux_R         = MUX_R_KEEP;
    mux_D         = MUX_D_KEEP;
    mux_Z         = MUX_Z_KEEP;
    result_signed = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Mealy load: operands go into R/D in the same cycle as start.
          mux_R        = dec_load_neg_a ? MUX_R_A_NEG : MUX_R_A;
          mux_D        = dec_load_neg_b ? MUX_D_B_NEG : MUX_D_B;
          mux_Z        = MUX_Z_ZERO;
          a_signed_d   = dec_a_signed;
          b_signed_d   = dec_b_signed;
          res_signed_d = dec_result_signed;
          result_sel_d = dec_result_sel;
          negate_d     = dec_negate;
          if (dec_is_div) begin
            state_d = DIV_ITER;
            cnt_d   = CNT_W'(DIV_STEPS - 1);
          end else begin
            state_d = MUL_OPS;
          end
        end
      end

      MUL_OPS: begin
        busy    = 1'b1;
        mux_A   = a_signed_q ? MUX_A_SIGNED : MUX_A_UNSIGNED;
        mux_B   = b_signed_q ? MUX_B_SIGNED : MUX_B_UNSIGNED;
        cnt_d   = CNT_W'(MUL_LATENCY - 1);
        state_d = MUL_WAIT;
      end

      MUL_WAIT: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = MUL_CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      MUL_CAPTURE: begin
        busy          = 1'b1;
        mux_R         = MUX_R_MULT_LOWER;
        mux_Z         = MUX_Z_MULT_UPPER;
        result_signed = res_signed_q;
        state_d       = DONE;
      end

      DIV_ITER: begin
        busy  = 1'b1;
        // A borrow means the trial subtraction failed: the partial remainder
        // is left untouched and only the quotient/divisor shift.
        mux_R = sub_neg ? MUX_R_KEEP : MUX_R_SUB_KEEP;
        mux_Z = MUX_Z_SHL_ADD;
        mux_D = MUX_D_SHR;
        mux_A = MUX_A_ZERO;
        mux_B = MUX_B_ZERO;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
